// File: rtl/iter_mdu_if.sv
// iter_mdu_if: decode/ID-EX side handshake of the iterative multiply/divide unit
interface iter_mdu_if #(
  parameter int XLEN = 32
);
  logic start;
  logic [4:0] alu_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic flush;
  logic busy;
  logic valid;
  logic [XLEN-1:0] result;
  logic stall_req;
  modport master (
    output start, alu_op, src_a, src_b, flush,
    input busy, valid, result, stall_req
  );
  modport slave (
    input start, alu_op, src_a, src_b, flush,
    output busy, valid, result, stall_req
  );
endinterface

// File: rtl/iter_mdu.sv
// iter_mdu: iterative RV32M multiply/divide unit; define MDU_FAST_MUL_EN for a single-cycle multiplier
module iter_mdu #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic clk,
  input logic rst_n,
  iter_mdu_if.slave m
);
  localparam int CW = $clog2(ITER);
  localparam logic [4:0] MUL = 5'b01011;
  localparam logic [4:0] MULH = 5'b01100;
  localparam logic [4:0] MULHSU = 5'b01101;
  localparam logic [4:0] MULHU = 5'b01110;
  localparam logic [4:0] DIV = 5'b01111;
  localparam logic [4:0] DIVU = 5'b10000;
  localparam logic [4:0] REM = 5'b10001;
  localparam logic [4:0] REMU = 5'b10010;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [4:0] op;
  logic [XLEN-1:0] hi, lo, opd, result, mag_a, mag_b, spec_res, nxt_hi, nxt_lo, prod_hi, fin;
  logic [XLEN:0] sum, sh, diff;
  logic res_neg, is_m, div_in, sgn_a, sgn_b, neg_in, special, ge;
  always_comb begin
    is_m = m.start && m.alu_op >= MUL && m.alu_op <= REMU;
    div_in = m.alu_op >= DIV;
    sgn_a = m.alu_op inside {MULH, MULHSU, DIV, REM};
    sgn_b = m.alu_op inside {MULH, DIV, REM};
    mag_a = sgn_a && m.src_a[XLEN-1] ? -m.src_a : m.src_a;
    mag_b = sgn_b && m.src_b[XLEN-1] ? -m.src_b : m.src_b;
    neg_in = (sgn_a && m.src_a[XLEN-1]) ^ (sgn_b && m.src_b[XLEN-1] && m.alu_op != REM);
    special = div_in && (m.src_b == '0 || (sgn_b && m.src_a == {1'b1, {XLEN-1{1'b0}}} && m.src_b == '1));
    spec_res = m.src_b == '0 ? (m.alu_op inside {DIV, DIVU} ? '1 : m.src_a) : (m.alu_op == DIV ? m.src_a : '0);
    // hi:lo is the product for multiplies and remainder:quotient for divides
    sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    sh = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, opd};
    ge = !diff[XLEN];
    nxt_hi = op < DIV ? sum[XLEN:1] : ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
    nxt_lo = op < DIV ? {sum[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], ge};
    // upper half of the 2*XLEN negation: borrow from the low half only when it is zero
    prod_hi = res_neg ? ~nxt_hi + {{XLEN-1{1'b0}}, nxt_lo == '0} : nxt_hi;
    fin = op == MUL ? nxt_lo : op < DIV ? prod_hi : op inside {DIV, DIVU} ? (res_neg ? -nxt_lo : nxt_lo) : (res_neg ? -nxt_hi : nxt_hi);
  end
`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0] fa, fb;
  logic signed [2*XLEN+1:0] fp;
  logic [XLEN-1:0] fast_res;
  always_comb begin
    fa = {sgn_a & m.src_a[XLEN-1], m.src_a};
    fb = {sgn_b & m.src_b[XLEN-1], m.src_b};
    fp = (2*XLEN+2)'(fa) * (2*XLEN+2)'(fb);
    fast_res = m.alu_op == MUL ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
  end
`endif
  assign m.busy = state != IDLE;
  assign m.valid = state == DONE;
  assign m.result = result;
  assign m.stall_req = (state == IDLE && is_m) || state == CALC;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      op <= '0;
      hi <= '0;
      lo <= '0;
      opd <= '0;
      res_neg <= 1'b0;
      result <= '0;
    end else if (m.flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (is_m) begin
          op <= m.alu_op;
          res_neg <= neg_in;
          count <= '0;
          hi <= '0;
          lo <= div_in ? mag_a : mag_b;
          opd <= div_in ? mag_b : mag_a;
          if (special) begin
            result <= spec_res;
            state <= DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!div_in) begin
            result <= fast_res;
            state <= DONE;
          end
`endif
          else state <= CALC;
        end
        CALC: begin
          hi <= nxt_hi;
          lo <= nxt_lo;
          count <= count + 1'b1;
          if (count == CW'(ITER - 1)) begin
            result <= fin;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_mdu.sv
// tb_iter_mdu: scoreboard bench for iter_mdu (latency, stall, flush and reset behaviour)
module tb_iter_mdu;
  localparam logic [4:0] ADD = 5'b00000;
  localparam logic [4:0] MUL = 5'b01011;
  localparam logic [4:0] MULH = 5'b01100;
  localparam logic [4:0] MULHSU = 5'b01101;
  localparam logic [4:0] MULHU = 5'b01110;
  localparam logic [4:0] DIV = 5'b01111;
  localparam logic [4:0] DIVU = 5'b10000;
  localparam logic [4:0] REM = 5'b10001;
  localparam logic [4:0] REMU = 5'b10010;
`ifdef MDU_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  iter_mdu_if #(.XLEN(32)) bus();
  iter_mdu #(.XLEN(32), .ITER(32)) dut (.clk(clk), .rst_n(rst_n), .m(bus));
  int checks = 0;
  int failures = 0;
  int vcount = 0;
  logic [31:0] sb[$];
  logic [31:0] last_exp = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.valid) begin
      vcount++;
      if (sb.size() == 0) check("spurious_valid", 64'(bus.valid), 64'd0);
      else check("result", bus.result, sb.pop_front());
    end
  end
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    int stalls;
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_op = op;
    bus.src_a = a;
    bus.src_b = b;
    sb.push_back(exp);
    last_exp = exp;
    #1 check("stall_accept", 64'(bus.stall_req), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    stalls = 0;
    while (!bus.valid && n < 60) begin
      if (bus.stall_req) stalls++;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(lat));
    check("stall_cycles", 64'(stalls), 64'(lat - 1));
    check("stall_in_valid", 64'(bus.stall_req), 64'd0);
    check("busy_in_valid", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("idle_after", 64'(bus.busy), 64'd0);
  endtask
  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    int v0;
    bus.start = 1'b0;
    bus.alu_op = ADD;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_stall", 64'(bus.stall_req), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MLAT);
    run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT);
    run_op(MULH, 32'h80000000, 32'h80000000, 32'h40000000, MLAT);
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MLAT);
    run_op(MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, MLAT);
    run_op(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op(DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op(REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op(DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op(REM, 32'd5, 32'd0, 32'd5, 1);
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op(REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      run_op(MULHU, a, b, p[63:32], MLAT);
      b = $urandom_range(1, 1000);
      run_op(DIVU, a, b, a / b, 33);
      run_op(REMU, a, b, a % b, 33);
    end
    // flush once the iteration counter reaches 10
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_op = DIVU;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_flush", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_idle", 64'(bus.busy), 64'd0);
    check("flush_result_hold", 64'(bus.result), 64'(last_exp));
    v0 = vcount;
    repeat (40) @(negedge clk);
    check("flush_no_valid", 64'(vcount), 64'(v0));
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.alu_op = MUL;
    bus.src_a = 32'd3;
    bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start_flush_idle", 64'(bus.busy), 64'd0);
    v0 = vcount;
    repeat (40) @(negedge clk);
    check("start_flush_no_valid", 64'(vcount), 64'(v0));
    bus.start = 1'b1;
    bus.alu_op = ADD;
    #1 check("add_no_stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("add_no_busy", 64'(bus.busy), 64'd0);
    // reset mid-divide at count 20
    bus.start = 1'b1;
    bus.alu_op = DIVU;
    bus.src_a = 32'd12345;
    bus.src_b = 32'd11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_valid", 64'(bus.valid), 64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MUL, 32'd6, 32'd7, 32'd42, MLAT);
    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
